fc_stream_tx: RTL and testbench

//  AXI4-Stream transmitter for the FC datapath: replays a locally loaded word buffer as one

---
 rtl/fc_pkg.sv | 8 +
 rtl/fc_stream_tx_if.sv | 11 +
 rtl/fc_tx_skid.sv | 35 +++
 rtl/fc_stream_tx.sv | 94 +++++++++
 tb/tb_fc_stream_tx.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared defaults, FSM states and stream constants for the FC stream transmitter
package fc_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF = 21;
  localparam int DEPTH_DEF = 1024;
  localparam logic [DATA_W_DEF/8-1:0] TKEEP_ALL = '1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} tx_state_t;
endpackage

// File: rtl/fc_stream_tx_if.sv
// fc_stream_tx_if: AXI4-Stream bundle between the FC transmitter and its sink
interface fc_stream_tx_if import fc_pkg::*; #(parameter int DATA_W = DATA_W_DEF);
  logic TVALID;
  logic TREADY;
  logic TUSER;
  logic TLAST;
  logic [DATA_W-1:0] TDATA;
  logic [DATA_W/8-1:0] TKEEP;
  modport master(output TVALID, TDATA, TKEEP, TUSER, TLAST, input TREADY);
  modport slave(input TVALID, TDATA, TKEEP, TUSER, TLAST, output TREADY);
endinterface

// File: rtl/fc_tx_skid.sv
// fc_tx_skid: 2-entry skid stage; space_o is registered so upstream reads never wait on ready_i
module fc_tx_skid #(parameter int W = 34) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         space_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         ready_i
);
  logic [1:0] cnt_q, cnt_d;
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic pop;
  assign pop = valid_o && ready_i;
  assign valid_o = cnt_q != 2'd0;
  assign space_o = cnt_q != 2'd2;
  assign data_o = e0_q;
  // e0 is the presented head; e1 only fills when a push lands behind an unconsumed head
  always_comb begin
    e0_d = pop ? (cnt_q == 2'd2 ? e1_q : data_i) : (cnt_q == 2'd0 ? data_i : e0_q);
    e1_d = (push_i && !pop && cnt_q == 2'd1) ? data_i : e1_q;
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
endmodule

// File: rtl/fc_stream_tx.sv
// fc_stream_tx: replays a local word buffer as one framed AXI4-Stream burst into the FC S_AXIS port
// Define FC_TX_STALL_CNT_EN to build the backpressure cycle counter behind STALL_CNT.
module fc_stream_tx import fc_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LEN_W = LEN_W_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              START,
  input  logic [LEN_W-1:0]  LEN,
  fc_stream_tx_if.master    M_AXIS,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [31:0]       STALL_CNT
);
  tx_state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, rd_q, rd_d;
  logic err_q, err_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic space, rd_en, start_ok, len_bad, pop, tvalid, skid_user, skid_last;
  logic [DATA_W-1:0] skid_data;
  assign len_bad = LEN > LEN_W'(DEPTH);
  assign start_ok = state_q == IDLE && START && !len_bad;
  assign rd_en = state_q == RUN && space && rd_q != len_q;
  assign pop = tvalid && M_AXIS.TREADY;
  always_ff @(posedge CLK)
    if (WR_EN && state_q != RUN) mem[WR_ADDR] <= WR_DATA;
  // the skid entry register doubles as the buffer's read register, giving START->TVALID of two cycles
  fc_tx_skid #(.W(DATA_W + 2)) u_skid (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (rd_en),
    .data_i  ({rd_q == '0, rd_q == len_q - LEN_W'(1), mem[rd_q[ADDR_W-1:0]]}),
    .space_o (space),
    .valid_o (tvalid),
    .data_o  ({skid_user, skid_last, skid_data}),
    .ready_i (M_AXIS.TREADY)
  );
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    rd_d = rd_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        err_d = len_bad;
        state_d = len_bad ? IDLE : (LEN == '0 ? FIN : RUN);
        len_d = len_bad ? len_q : LEN;
        rd_d = '0;
      end
      RUN: begin
        rd_d = rd_en ? rd_q + LEN_W'(1) : rd_q;
        state_d = (pop && skid_last) ? FIN : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      len_q <= '0;
      rd_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      rd_q <= rd_d;
      err_q <= err_d;
    end
  assign M_AXIS.TVALID = tvalid;
  assign M_AXIS.TDATA = skid_data;
  assign M_AXIS.TUSER = tvalid && skid_user;
  assign M_AXIS.TLAST = tvalid && skid_last;
  assign M_AXIS.TKEEP = {(DATA_W/8){tvalid}};
  assign BUSY = state_q == RUN;
  assign DONE = state_q == FIN;
  assign ERR = err_q;
`ifdef FC_TX_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) stall_q <= '0;
    else if (start_ok) stall_q <= '0;
    else if (tvalid && !M_AXIS.TREADY && stall_q != '1) stall_q <= stall_q + 32'd1;
  assign STALL_CNT = stall_q;
`else
  assign STALL_CNT = '0;
`endif
endmodule

// File: tb/tb_fc_stream_tx.sv
// tb_fc_stream_tx: table-driven frame checks plus a mid-frame reset sequence for fc_stream_tx
module tb_fc_stream_tx;
  import fc_pkg::*;
  localparam int DEPTH = DEPTH_DEF;
  localparam int LEN_W = LEN_W_DEF;
  localparam int AW = $clog2(DEPTH);
`ifdef FC_TX_STALL_CNT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RST, WR_EN, START, BUSY, DONE, ERR;
  logic [AW-1:0] WR_ADDR;
  logic [31:0] WR_DATA, STALL_CNT;
  logic [LEN_W-1:0] LEN;
  fc_stream_tx_if #(.DATA_W(32)) m_axis ();
  fc_stream_tx dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .START(START), .LEN(LEN), .M_AXIS(m_axis), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .STALL_CNT(STALL_CNT)
  );
  always #5 CLK = ~CLK;
  logic [31:0] model [DEPTH];
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    int len;
    logic [31:0] rdy;
    int exp_done;
    int exp_stall;
    bit exp_err;
    int inj;
    bit co_wr;
  } vec_t;
  vec_t vecs [10];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // rdy bit k is TREADY in the k-th cycle after START; cycle 0 is the START cycle
  task automatic run_frame(input vec_t v);
    int cyc = 0;
    int beat = 0;
    int first = -1;
    bit err_seen = 0, stl = 0, extra = 0, done = 0;
    logic [33:0] prev = '0;
    @(negedge CLK);
    START = 1'b1;
    LEN = LEN_W'(v.len);
    m_axis.TREADY = 1'b1;
    if (v.co_wr) begin
      WR_EN = 1'b1;
      WR_ADDR = '0;
      WR_DATA = 32'h55AA_0000 + 32'(v.len);
      model[0] = WR_DATA;
    end
    while (!done && cyc < (v.exp_err ? 4 : v.exp_done + 20)) begin
      @(negedge CLK);
      cyc++;
      START = 1'b0;
      WR_EN = 1'b0;
      if (cyc == v.inj) begin
        START = 1'b1;
        LEN = LEN_W'(2);
        WR_EN = 1'b1;
        WR_ADDR = AW'(5);
        WR_DATA = 32'hDEAD_BEEF;
      end
      err_seen |= ERR;
      if (cyc == 1) check("busy_after_start", BUSY, v.len > 0 && !v.exp_err);
      if (stl) check("stall_hold", {m_axis.TVALID, m_axis.TUSER, m_axis.TLAST, m_axis.TDATA}, {1'b1, prev});
      if (m_axis.TVALID) begin
        if (first < 0) first = cyc;
        if (beat >= v.len) extra = 1'b1;
        else begin
          check("tdata", m_axis.TDATA, model[beat]);
          check("tuser", m_axis.TUSER, beat == 0);
          check("tlast", m_axis.TLAST, beat == v.len - 1);
          check("tkeep", m_axis.TKEEP, TKEEP_ALL);
        end
      end
      m_axis.TREADY = v.rdy[cyc % 32];
      stl = m_axis.TVALID && !m_axis.TREADY;
      prev = {m_axis.TUSER, m_axis.TLAST, m_axis.TDATA};
      if (m_axis.TVALID && m_axis.TREADY) beat++;
      if (DONE) begin
        done = 1'b1;
        check("done_cycle", cyc, v.exp_done);
        check("beat_count", beat, v.len);
        check("first_valid_cycle", first, v.len > 0 ? 2 : -1);
        check("stall_cnt", STALL_CNT, STALL_ON ? v.exp_stall : 0);
        check("busy_at_done", BUSY, 1'b0);
      end
    end
    if (v.exp_err) begin
      check("err_pulse", err_seen, 1'b1);
      check("err_no_done", done, 1'b0);
      check("err_no_beats", beat, 0);
    end else begin
      check("done_seen", done, 1'b1);
      check("no_err", err_seen, 1'b0);
    end
    check("no_extra_beat", extra, 1'b0);
  endtask
  initial begin
    RST = 1'b0;
    WR_EN = 1'b0;
    START = 1'b0;
    WR_ADDR = '0;
    WR_DATA = '0;
    LEN = '0;
    m_axis.TREADY = 1'b0;
    #1 RST = 1'b1;
    #1;
    check("rst_tvalid", m_axis.TVALID, 1'b0);
    check("rst_flags", {m_axis.TUSER, m_axis.TLAST, m_axis.TKEEP}, '0);
    check("rst_status", {BUSY, DONE, ERR}, 3'b000);
    check("rst_stall", STALL_CNT, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge CLK);
      WR_EN = 1'b1;
      WR_ADDR = AW'(i);
      WR_DATA = 32'h100 + 32'(i);
      model[i] = WR_DATA;
    end
    @(negedge CLK);
    WR_EN = 1'b0;
    vecs = '{
      '{8,         32'hFFFF_FFFF, 10,        0, 1'b0, 0, 1'b0},
      '{8,         32'hFFFF_FD57, 14,        4, 1'b0, 0, 1'b0},
      '{3,         32'hFFFF_FFE1, 8,         3, 1'b0, 0, 1'b0},
      '{1,         32'hFFFF_FFFF, 3,         0, 1'b0, 0, 1'b0},
      '{1,         32'hFFFF_FFFF, 3,         0, 1'b0, 0, 1'b1},
      '{0,         32'hFFFF_FFFF, 1,         0, 1'b0, 0, 1'b0},
      '{DEPTH + 1, 32'hFFFF_FFFF, -1,        0, 1'b1, 0, 1'b0},
      '{8,         32'hFFFF_FFFF, 10,        0, 1'b0, 5, 1'b0},
      '{8,         32'hFFFF_FFFF, 10,        0, 1'b0, 0, 1'b0},
      '{DEPTH,     32'hFFFF_FFFF, DEPTH + 2, 0, 1'b0, 0, 1'b0}
    };
    foreach (vecs[i]) run_frame(vecs[i]);
    // abort: reset lands while beat 5 of an 8-beat frame is presented
    @(negedge CLK);
    START = 1'b1;
    LEN = LEN_W'(8);
    m_axis.TREADY = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK);
      START = 1'b0;
    end
    check("pre_abort_data", {m_axis.TVALID, m_axis.TDATA}, {1'b1, model[5]});
    RST = 1'b1;
    #1;
    check("abort_tvalid", m_axis.TVALID, 1'b0);
    check("abort_busy", BUSY, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("abort_quiet", {m_axis.TVALID, m_axis.TLAST, DONE}, 3'b000);
    end
    check("abort_stall", STALL_CNT, 32'd0);
    RST = 1'b0;
    run_frame('{2, 32'hFFFF_FFFF, 4, 0, 1'b0, 0, 1'b0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
